axis_udp_rx_ingress: RTL



---
 rtl/udp_pkg.sv | 23 ++
 rtl/axis_udp_rx_ingress.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/udp_pkg.sv
// Shared UDP receive-path definitions: header sizes, beat arithmetic
// and the ingress FSM state type.
package udp_pkg;

    localparam int ETH_HDR_BYTES   = 14;
    localparam int IPV4_HDR_BYTES  = 20;
    localparam int UDP_HDR_BYTES   = 8;
    localparam int IPV4_ADDR_WIDTH = 32;

    // Number of bus beats needed to carry 'bytes' bytes on a bus of 'data_width' bits.
    function automatic int beats_for_bytes(input int bytes, input int data_width);
        int bytes_per_beat;
        bytes_per_beat = data_width / 8;
        return (bytes + bytes_per_beat - 1) / bytes_per_beat;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } ingress_state_t;

endpackage

// File: rtl/axis_udp_rx_ingress.sv
// MAC receive AXI-Stream to push-only frame bus for the UDP filter.
// Gates whole frames on en_i (sampled at frame start), flags runts,
// truncates oversize frames and carries the MAC error on the last beat.
// Handshake: a beat moves when s_axis_tvalid_i && s_axis_tready_o on a
// rising clk_i; tready is held high from the first clock after reset, and
// the output side is push-only (frame_valid_o has no ready).
// Optional statistics counters: define UDP_INGRESS_STATS_EN.
module axis_udp_rx_ingress
    import udp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 190,
    parameter int MIN_BEATS  = beats_for_bytes(ETH_HDR_BYTES + IPV4_HDR_BYTES + UDP_HDR_BYTES,
                                               DATA_WIDTH),
    parameter int CNT_WIDTH  = 16,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tlast_i,
    input  logic                  s_axis_tuser_i,
    output logic                  s_axis_tready_o,
    output logic [DATA_WIDTH-1:0] frame_o,
    output logic [KEEP_WIDTH-1:0] frame_keep_o,
    output logic                  frame_valid_o,
    output logic                  frame_last_o,
`ifdef UDP_INGRESS_STATS_EN
    output logic [CNT_WIDTH-1:0]  rx_frames_o,
    output logic [CNT_WIDTH-1:0]  rx_err_o,
    output logic [CNT_WIDTH-1:0]  rx_drop_o,
`endif
    output logic                  frame_err_o
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W:0] MAX_L = (BEAT_W + 1)'(MAX_BEATS);
    localparam logic [BEAT_W:0] MIN_L = (BEAT_W + 1)'(MIN_BEATS);

    ingress_state_t          state_q, state_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    dis_q, dis_d;      // current DROP frame was refused by en_i
    logic                    tready_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
    logic                    valid_q, last_q, err_q;
    logic                    fwd_d, last_d, err_d, drop_done_d;
    logic                    accept;
    logic [BEAT_W:0]         cnt_inc;           // 1-based position of the incoming beat
    logic                    runt;

    assign accept  = s_axis_tvalid_i && tready_q;
    assign cnt_inc = {1'b0, beat_cnt_q} + (BEAT_W + 1)'(1);
    assign runt    = (cnt_inc < MIN_L);

    // Next-state, beat counter and forwarding decision for the accepted beat.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        dis_d       = dis_q;
        fwd_d       = 1'b0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        keep_d      = '1;
        drop_done_d = 1'b0;
        if (accept) begin
            if (s_axis_tlast_i) begin
                beat_cnt_d = '0;
            end else if (cnt_inc <= MAX_L) begin
                beat_cnt_d = cnt_inc[BEAT_W-1:0];
            end
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        fwd_d = 1'b1;
                        if (s_axis_tlast_i) begin
                            last_d = 1'b1;
                            err_d  = s_axis_tuser_i || runt;
                            keep_d = s_axis_tkeep_i;
                        end else begin
                            state_d = FWD;
                        end
                    end else if (s_axis_tlast_i) begin
                        drop_done_d = 1'b1;
                    end else begin
                        state_d = DROP;
                        dis_d   = 1'b1;
                    end
                end
                FWD: begin
                    fwd_d = 1'b1;
                    if (s_axis_tlast_i) begin
                        last_d  = 1'b1;
                        err_d   = s_axis_tuser_i || runt;
                        keep_d  = s_axis_tkeep_i;
                        state_d = IDLE;
                    end else if (cnt_inc == MAX_L) begin
                        // Oversize frame: close it here as bad, swallow the rest.
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DROP;
                        dis_d   = 1'b0;
                    end
                end
                DROP: begin
                    if (s_axis_tlast_i) begin
                        drop_done_d = dis_q;
                        dis_d       = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, beat counter and ready registers.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            dis_q      <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            dis_q      <= dis_d;
            tready_q   <= 1'b1;
        end
    end

    // Registered output beat, one cycle after acceptance.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= fwd_d;
            last_q  <= fwd_d && last_d;
            err_q   <= fwd_d && err_d;
            if (fwd_d) begin
                data_q <= s_axis_tdata_i;
                keep_q <= keep_d;
            end
        end
    end

    assign s_axis_tready_o = tready_q;
    assign frame_o         = data_q;
    assign frame_keep_o    = keep_q;
    assign frame_valid_o   = valid_q;
    assign frame_last_o    = last_q;
    assign frame_err_o     = err_q;

`ifdef UDP_INGRESS_STATS_EN
    logic [CNT_WIDTH-1:0] frames_q, errs_q, drops_q;

    // Frame statistics, wrapping counters.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            frames_q <= '0;
            errs_q   <= '0;
            drops_q  <= '0;
        end else begin
            if (valid_q && last_q && !err_q) frames_q <= frames_q + CNT_WIDTH'(1);
            if (valid_q && last_q && err_q)  errs_q   <= errs_q + CNT_WIDTH'(1);
            if (drop_done_d)                 drops_q  <= drops_q + CNT_WIDTH'(1);
        end
    end

    assign rx_frames_o = frames_q;
    assign rx_err_o    = errs_q;
    assign rx_drop_o   = drops_q;
`endif

endmodule
